// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: bundles the FIFO read port and the outgoing valid/ready stream.
// master: the reader block. slave: the FIFO plus the stream consumer.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  // FIFO read port
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Output stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO (one-cycle read latency) and presents
// them as a valid/ready stream through a 2-entry buffer. Reads are credit-limited so the buffer
// never overflows; words in flight when enable drops or Empty rises are still captured.
// Optional burst marking on m_last is built only when FIFO_STREAM_READER_LAST_EN is defined;
// otherwise m_last is tied low.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 enable,
  fifo_stream_reader_if.master bus
);

  if (BURST_LEN < 2 || BURST_LEN > 65535) begin : gen_burst_len_check
    $fatal(1, "fifo_stream_reader: BURST_LEN must be in 2..65535");
  end

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q;
  logic                  head_q;
  logic                  tail_q;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic       m_valid;
  logic       pop;
  logic       capture;
  logic       rd_en;
  logic [1:0] occ_cnt;

  assign occ_cnt = occ_q;
  assign m_valid = (occ_q != StEmpty);
  assign pop     = m_valid & bus.m_ready;
  // The word read last cycle is on fifo_data now.
  assign capture = inflight_q;

  // occ + inflight - pop < 2, rearranged to avoid a signed subtraction. The pop term gives
  // same-cycle credit when the consumer accepts.
  assign rd_en = reset & enable & ~bus.fifo_empty &
                 (({1'b0, occ_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // Occupancy next-state: capture adds one, pop removes one, both together cancel.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      StEmpty: begin
        if (capture) occ_d = StOne;
      end
      StOne: begin
        if (capture && !pop)      occ_d = StTwo;
        else if (!capture && pop) occ_d = StEmpty;
      end
      StTwo: begin
        if (pop && !capture) occ_d = StOne;
      end
      default: occ_d = StEmpty;
    endcase
  end

  // Occupancy, in-flight flag, pointers and buffer storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q      <= StEmpty;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd_en;
      if (capture) begin
        buf_q[tail_q] <= bus.fifo_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  // Head entry is a register and only changes on pop or capture into an empty buffer,
  // so data is stable under backpressure.
  assign bus.m_data     = buf_q[head_q];

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int unsigned CntW = $clog2(BURST_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  logic [CntW-1:0] beat_q;

  // Beat counter: advances on each accepted beat, wraps at the end of a burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
    end
  end

  assign bus.m_last = m_valid & (beat_q == LastBeat);
`else
  assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench with a behavioural FIFO and a scoreboard of expected
// beats. m_last expectations follow FIFO_STREAM_READER_LAST_EN the same way the design does.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];

  int cyc;
  int rd_count;
  int valid_count;
  int pop_count;
  int last_count;
  int first_rd_cyc;
  int first_valid_cyc;
  int last_valid_cyc;
  int last_pop_cyc;
  int beat;
  int rel_cyc;
  int budget;

  logic          rd_s;
  logic          valid_s;
  logic          last_s;
  logic [DW-1:0] data_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc             = 0;
    rd_count        = 0;
    valid_count     = 0;
    pop_count       = 0;
    last_count      = 0;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    last_valid_cyc  = -1;
    last_pop_cyc    = -1;
  endtask

  task automatic load(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem.push_back(DW'(start + i));
      exp_q.push_back(DW'(start + i));
    end
    bus.fifo_empty = (fifo_mem.size() == 0);
  endtask

  // Called at posedge+1 with inputs set; samples at posedge+3, returns at next posedge+1.
  task automatic cycle();
    logic [DW-1:0] w;
    logic          exp_last;
    #2;
    rd_s    = bus.fifo_rd_en;
    valid_s = bus.m_valid;
    data_s  = bus.m_data;
    last_s  = bus.m_last;
    chk("rd_on_empty", 32'(rd_s & bus.fifo_empty), 32'd0);
    if (rd_s) begin
      rd_count++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (valid_s) begin
      valid_count++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
    end else begin
      chk("last_idle", 32'(last_s), 32'd0);
    end
    if (valid_s && bus.m_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("beat_data", 32'(data_s), 32'(w));
`ifdef FIFO_STREAM_READER_LAST_EN
        exp_last = (beat == int'(BL) - 1);
`else
        exp_last = 1'b0;
`endif
        chk("beat_last", 32'(last_s), 32'(exp_last));
        beat = (beat == int'(BL) - 1) ? 0 : beat + 1;
        pop_count++;
        last_pop_cyc = cyc;
        if (last_s) last_count++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s && fifo_mem.size() != 0) bus.fifo_data = fifo_mem.pop_front();
    bus.fifo_empty = (fifo_mem.size() == 0);
  endtask

  task automatic drain(input int limit);
    budget = limit;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_complete", exp_q.size(), 32'd0);
  endtask

  // Resets the block together with the FIFO model and the scoreboard.
  task automatic apply_reset();
    reset = 1'b0;
    fifo_mem.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    beat = 0;
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    enable         = 1'b1;
    bus.m_ready    = 1'b1;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    beat           = 0;
    clear_stats();
    @(posedge clk);
    #1;

    // Reset hold with a non-empty FIFO.
    load(32'hA5, 1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_rd_en", 32'(rd_s), 32'd0);
      chk("rst_valid", 32'(valid_s), 32'd0);
      chk("rst_data", 32'(data_s), 32'd0);
      chk("rst_last", 32'(last_s), 32'd0);
    end

    // Single word: read in the first cycle after reset rises, valid two cycles later.
    reset = 1'b1;
    clear_stats();
    cycle();
    chk("rd_after_reset", 32'(rd_s), 32'd1);
    repeat (5) cycle();
    chk("single_rd_count", rd_count, 32'd1);
    chk("single_first_rd", first_rd_cyc, 32'd0);
    chk("single_valid_count", valid_count, 32'd1);
    chk("single_latency", first_valid_cyc - first_rd_cyc, 32'd2);
    chk("single_pops", pop_count, 32'd1);

    // Streaming 32 words with no backpressure.
    clear_stats();
    load(0, 32);
    drain(80);
    chk("stream_rd_count", rd_count, 32'd32);
    chk("stream_valid_count", valid_count, 32'd32);
    chk("stream_contiguous", last_valid_cyc - first_valid_cyc + 1, 32'd32);
    chk("stream_pops", pop_count, 32'd32);

    // Backpressure for 10 cycles starting at beat 5.
    clear_stats();
    load(0, 32);
    budget = 40;
    while (pop_count < 5 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("bp_reach_beat5", pop_count, 32'd5);
    bus.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_valid", 32'(valid_s), 32'd1);
      chk("bp_data_held", 32'(data_s), 32'h05);
      if (k >= 1) chk("bp_rd_low", 32'(rd_s), 32'd0);
    end
    bus.m_ready = 1'b1;
    rel_cyc = cyc;
    drain(80);
    chk("bp_pops", pop_count, 32'd32);
    chk("bp_no_gap", last_pop_cyc - rel_cyc + 1, 32'd27);
    chk("bp_rd_count", rd_count, 32'd32);

    // Burst marking over 8 beats.
    apply_reset();
    clear_stats();
    load(0, 8);
    drain(40);
    chk("burst_pops", pop_count, 32'd8);
`ifdef FIFO_STREAM_READER_LAST_EN
    chk("burst_last_count", last_count, 32'd2);
`else
    chk("burst_last_count", last_count, 32'd0);
`endif

    // Reset in the middle of a stream with a word in flight.
    clear_stats();
    load(32'h10, 16);
    budget = 40;
    while (pop_count < 3 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("mid_reach_beat3", pop_count, 32'd3);
    bus.m_ready = 1'b0;
    apply_reset();
    cycle();
    chk("mid_valid_after_rst", 32'(valid_s), 32'd0);
    bus.m_ready = 1'b1;
    clear_stats();
    load(32'h40, 2);
    drain(20);
    chk("mid_pops", pop_count, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
